regfile_write_queue: RTL and testbench

REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

---
 rtl/regfile_write_queue.sv | 126 ++++++++++++
 tb/tb_regfile_write_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue
// -------------------
// Buffers register-file write requests in a small circular FIFO. Each cycle
// the head entry is written to the register file unless hold is high. Pending
// entries are searched combinationally so that reads of a register with a
// write still in flight can take the youngest pending value.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   in_valid/in_ready     producer handshake; in_ready = !full
//   in_reg, in_data       destination register index and data
//   hold                  stalls draining (acceptance unaffected)
//   RegWrite              register file write enable (head valid and not held)
//   WriteRegister/Data    head entry, driven to 0 when empty
//   ReadRegister1/2       read indices to look up in the pending entries
//   fwd_hit1/2            a pending write targets that read index
//   fwd_data1/2           youngest pending data for that index, 0 on miss
//   count, empty, full    occupancy
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_reg,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     hold,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [WIDTH-1:0]         WriteData,
  input  logic [4:0]               ReadRegister1,
  input  logic [4:0]               ReadRegister2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [WIDTH-1:0]         fwd_data1,
  output logic [WIDTH-1:0]         fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Register 31 is the hardwired sink: writes to it are accepted and dropped,
  // and it never forwards.
  localparam logic [4:0] SINK_REG = 5'd31;

  logic [4:0]       regMem  [DEPTH];
  logic [WIDTH-1:0] dataMem [DEPTH];

  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic             pushEn;
  logic             popEn;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;

  // Only requests that will actually write something occupy a slot.
  assign pushEn = in_valid && in_ready && (in_reg != SINK_REG);
  assign popEn  = !empty && !hold;

  assign RegWrite      = popEn;
  assign WriteRegister = empty ? '0 : regMem[headPtr];
  assign WriteData     = empty ? '0 : dataMem[headPtr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (pushEn) tailPtr <= tailPtr + 1'b1;
      if (popEn)  headPtr <= headPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; its contents are only observable
  // through occupied slots, and count/pointers are reset instead.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      regMem[tailPtr]  <= in_reg;
      dataMem[tailPtr] <= in_data;
    end
  end

  // Walk occupied slots from oldest (head) to youngest; a later match
  // overwrites an earlier one so the youngest pending value wins. The head
  // slot is included even while it is being written this cycle.
  logic [PTR_W-1:0] slot;

  // NOTE: every signal written in this block gets a default first so no
  // latch is inferred on paths where no slot matches.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    slot      = headPtr;
    for (int i = 0; i < DEPTH; i++) begin
      slot = headPtr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (regMem[slot] == ReadRegister1 && ReadRegister1 != SINK_REG) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = dataMem[slot];
        end
        if (regMem[slot] == ReadRegister2 && ReadRegister2 != SINK_REG) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = dataMem[slot];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue. A queue of pending writes
// models the FIFO; every cycle all outputs are compared against it at the
// falling edge, and the model advances at the rising edge.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_reg;
  logic [WIDTH-1:0] in_data;
  logic             hold;
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic             fwd_hit1;
  logic             fwd_hit2;
  logic [WIDTH-1:0] fwd_data1;
  logic [WIDTH-1:0] fwd_data2;
  logic [2:0]       count;
  logic             empty;
  logic             full;

  regfile_write_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg        (in_reg),
    .in_data       (in_data),
    .hold          (hold),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
    .count         (count),
    .empty         (empty),
    .full          (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       r;
    logic [WIDTH-1:0] d;
  } entry_t;

  entry_t model[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Youngest pending value for a read index, from the model.
  task automatic lookup(input logic [4:0] rr, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    if (rr != 5'd31) begin
      foreach (model[i]) begin
        if (model[i].r == rr) begin
          hit = 1'b1;
          d   = model[i].d;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int n;
    logic h1, h2;
    logic [63:0] d1, d2;
    n = model.size();
    lookup(ReadRegister1, h1, d1);
    lookup(ReadRegister2, h2, d2);
    check("count", 64'(count), 64'(n));
    check("empty", 64'(empty), 64'(n == 0));
    check("full", 64'(full), 64'(n == DEPTH));
    check("in_ready", 64'(in_ready), 64'(n != DEPTH));
    check("RegWrite", 64'(RegWrite), 64'(n > 0 && !hold));
    check("WriteRegister", 64'(WriteRegister), n > 0 ? 64'(model[0].r) : 64'd0);
    check("WriteData", WriteData, n > 0 ? model[0].d : 64'd0);
    check("fwd_hit1", 64'(fwd_hit1), 64'(h1));
    check("fwd_data1", fwd_data1, d1);
    check("fwd_hit2", 64'(fwd_hit2), 64'(h2));
    check("fwd_data2", fwd_data2, d2);
  endtask

  // One clock: check at the falling edge, advance the model at the rising
  // edge, return just after it so the caller can drive new inputs.
  task automatic cycle();
    logic doPop, doPush;
    entry_t e;
    @(negedge clk);
    if (reset) model.delete();
    check_outputs();
    doPop  = model.size() > 0 && !hold;
    doPush = in_valid && model.size() < DEPTH && in_reg != 5'd31;
    e.r = in_reg;
    e.d = in_data;
    @(posedge clk);
    if (!reset) begin
      if (doPop)  void'(model.pop_front());
      if (doPush) model.push_back(e);
    end
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [63:0] d);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_reg = '0;
    in_data = '0;
    hold = 1'b0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;

    // Reset state, before any clock edge.
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_RegWrite", 64'(RegWrite), 64'd0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Single write into an empty queue: visible the next cycle, gone after.
    push(5'd5, 64'hA5);
    check("lat_RegWrite", 64'(RegWrite), 64'd1);
    check("lat_WriteRegister", 64'(WriteRegister), 64'd5);
    check("lat_WriteData", WriteData, 64'hA5);
    cycle();
    check("lat_empty_after", 64'(empty), 64'd1);

    // Fill while held, attempt an extra push when full, then drain in order.
    hold = 1'b1;
    for (int r = 1; r <= 4; r++) push(5'(r), 64'(r * 256));
    check("fill_full", 64'(full), 64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_count", 64'(count), 64'd4);
    push(5'd9, 64'hDEAD);
    check("fill_reject_count", 64'(count), 64'd4);
    hold = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      check("drain_order", 64'(WriteRegister), 64'(r));
      cycle();
    end
    check("drain_empty", 64'(empty), 64'd1);

    // Register 31 is accepted but never stored or written.
    push(5'd31, 64'hA0);
    check("r31_count", 64'(count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check("r31_no_write", 64'(RegWrite), 64'd0);
      cycle();
    end

    // Forwarding picks the youngest match; register 31 never hits.
    hold = 1'b1;
    push(5'd7, 64'h11);
    push(5'd7, 64'h22);
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd31;
    #1;
    check("fwd_young_hit1", 64'(fwd_hit1), 64'd1);
    check("fwd_young_data1", fwd_data1, 64'h22);
    check("fwd_r31_hit2", 64'(fwd_hit2), 64'd0);
    check("fwd_r31_data2", fwd_data2, 64'd0);
    hold = 1'b0;
    cycle();
    cycle();
    // A request being accepted is not forwarded until it is stored; once it
    // is the head being written, it is still forwarded.
    ReadRegister1 = 5'd12;
    in_valid = 1'b1;
    in_reg   = 5'd12;
    in_data  = 64'h1234;
    #1;
    check("fwd_same_cycle_miss", 64'(fwd_hit1), 64'd0);
    cycle();
    in_valid = 1'b0;
    check("fwd_head_hit", 64'(fwd_hit1), 64'd1);
    check("fwd_head_data", fwd_data1, 64'h1234);
    cycle();

    // Steady push and pop at count 2, wrapping the pointers.
    hold = 1'b1;
    push(5'd10, 64'h100);
    push(5'd11, 64'h101);
    hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("steady_count", 64'(count), 64'd2);
      in_valid = 1'b1;
      in_reg   = 5'(12 + k);
      in_data  = {$urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    check("steady_drained", 64'(empty), 64'd1);

    // Reset between edges with three entries pending and a write in flight.
    hold = 1'b1;
    push(5'd1, 64'h1);
    push(5'd2, 64'h2);
    push(5'd3, 64'h3);
    hold = 1'b0;
    #2;
    check("midrst_pre_RegWrite", 64'(RegWrite), 64'd1);
    reset = 1'b1;
    #1;
    model.delete();
    check("midrst_RegWrite", 64'(RegWrite), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_WriteData", WriteData, 64'd0);
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("midrst_no_write", 64'(RegWrite), 64'd0);
      cycle();
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid      = ($urandom % 4) != 0;
      in_reg        = ($urandom % 6 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      in_data       = {$urandom, $urandom};
      hold          = ($urandom % 3) == 0;
      ReadRegister1 = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      ReadRegister2 = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
